border_generator: RTL and testbench

BORDER_GENERATOR -- requirements
Module: border_generator

---
 rtl/border_generator.sv | 57 +++++
 tb/tb_border_generator.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/border_generator.sv
// Border/corner/edge decoder for a square COORD_W-bit grid, plus a registered
// border flag and a saturating count of cycles spent on the border.
module border_generator #(
  parameter int COORD_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  output logic               isBorder,
  output logic               isCorner,
  output logic [3:0]         edge_flags,
  output logic               border_q,
  output logic [7:0]         border_cnt
);

  localparam logic [COORD_W-1:0] MAX = '1;
  localparam logic [7:0]         CNT_MAX = 8'hFF;

  logic       top, bottom, left, right;
  logic       border_d;
  logic [7:0] cnt_d;
  logic [7:0] cnt_q;

  always_comb begin
    top        = (y == '0);
    bottom     = (y == MAX);
    left       = (x == '0);
    right      = (x == MAX);
    edge_flags = {top, bottom, left, right};
    isBorder   = top | bottom | left | right;
    // MAX is never 0, so opposite edges cannot both be set; two set bits
    // always means one horizontal edge plus one vertical edge.
    isCorner   = (top | bottom) & (left | right);
  end

  always_comb begin
    border_d = isBorder;
    cnt_d    = cnt_q;
    if (isBorder && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      border_q <= 1'b0;
      cnt_q    <= 8'd0;
    end else begin
      border_q <= border_d;
      cnt_q    <= cnt_d;
    end
  end

  assign border_cnt = cnt_q;

endmodule

// File: tb/tb_border_generator.sv
// Directed bench for border_generator: exhaustive combinational sweep with the
// clock stopped, spot checks, registered flag latency, saturation and reset.
module tb_border_generator;

  localparam int COORD_W = 4;
  localparam int MAXV    = 15;

  logic               clk;
  logic               clk_en;
  logic               rst;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic               isBorder;
  logic               isCorner;
  logic [3:0]         edge_flags;
  logic               border_q;
  logic [7:0]         border_cnt;

  int n_tests;
  int n_fail;

  border_generator #(.COORD_W(COORD_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .x         (x),
    .y         (y),
    .isBorder  (isBorder),
    .isCorner  (isCorner),
    .edge_flags(edge_flags),
    .border_q  (border_q),
    .border_cnt(border_cnt)
  );

  // clock/reset block: the clock only toggles while clk_en is high
  initial clk = 1'b0;
  always #5 clk = clk_en ? ~clk : clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // inputs change 1 time unit after the rising edge, outputs sampled there too
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_xy(input int xv, input int yv);
    x = COORD_W'(xv);
    y = COORD_W'(yv);
  endtask

  initial begin
    int ones;
    int zeros;
    logic [3:0] exp_flags;
    logic       exp_border;
    logic       exp_corner;
    logic       sw_border;
    logic       sw_corner;

    n_tests = 0;
    n_fail  = 0;
    clk_en  = 1'b0;
    rst     = 1'b0;
    set_xy(7, 7);
    #2;

    // exhaustive sweep, no clock running
    ones  = 0;
    zeros = 0;
    for (int xi = 0; xi <= MAXV; xi++) begin
      for (int yi = 0; yi <= MAXV; yi++) begin
        set_xy(yi, xi);
        #1;
        sw_border = isBorder;
        sw_corner = isCorner;
        set_xy(xi, yi);
        #1;
        exp_flags  = {(yi == 0), (yi == MAXV), (xi == 0), (xi == MAXV)};
        exp_border = (xi == 0) || (xi == MAXV) || (yi == 0) || (yi == MAXV);
        exp_corner = ((xi == 0) || (xi == MAXV)) && ((yi == 0) || (yi == MAXV));
        check("sweep_border", 32'(isBorder), 32'(exp_border));
        check("sweep_corner", 32'(isCorner), 32'(exp_corner));
        check("sweep_flags", 32'(edge_flags), 32'(exp_flags));
        check("sweep_sym_border", 32'(sw_border), 32'(isBorder));
        check("sweep_sym_corner", 32'(sw_corner), 32'(isCorner));
        if (isBorder === 1'b1) ones++;
        if (isBorder === 1'b0) zeros++;
      end
    end
    check("sweep_ones", 32'(ones), 32'd60);
    check("sweep_zeros", 32'(zeros), 32'd196);

    // spot checks
    set_xy(0, 0); #1;
    check("spot00_border", 32'(isBorder), 32'd1);
    check("spot00_corner", 32'(isCorner), 32'd1);
    check("spot00_flags", 32'(edge_flags), 32'b1010);
    set_xy(15, 7); #1;
    check("spot157_border", 32'(isBorder), 32'd1);
    check("spot157_corner", 32'(isCorner), 32'd0);
    check("spot157_flags", 32'(edge_flags), 32'b0001);
    set_xy(7, 7); #1;
    check("spot77_border", 32'(isBorder), 32'd0);
    check("spot77_flags", 32'(edge_flags), 32'b0000);
    set_xy(15, 15); #1;
    check("spot1515_flags", 32'(edge_flags), 32'b0101);
    check("spot1515_corner", 32'(isCorner), 32'd1);

    // reset for one cycle, then (0,5) for three cycles
    clk_en = 1'b1;
    rst = 1'b1;
    set_xy(7, 7);
    tick();
    check("rst_border_q", 32'(border_q), 32'd0);
    check("rst_cnt", 32'(border_cnt), 32'd0);
    rst = 1'b0;
    set_xy(0, 5);
    tick();
    check("seq_border_q_1", 32'(border_q), 32'd1);
    check("seq_cnt_1", 32'(border_cnt), 32'd1);
    tick();
    check("seq_cnt_2", 32'(border_cnt), 32'd2);
    tick();
    check("seq_cnt_3", 32'(border_cnt), 32'd3);
    set_xy(7, 7);
    #1;
    check("seq_border_q_lag", 32'(border_q), 32'd1);
    tick();
    check("seq_border_q_off", 32'(border_q), 32'd0);
    check("seq_cnt_hold", 32'(border_cnt), 32'd3);

    // combinational outputs track inputs while rst is held
    rst = 1'b1;
    set_xy(15, 0);
    #1;
    check("rst_comb_border", 32'(isBorder), 32'd1);
    check("rst_comb_corner", 32'(isCorner), 32'd1);
    tick();
    check("rst_comb_flags", 32'(edge_flags), 32'b1001);
    check("rst_hold_cnt", 32'(border_cnt), 32'd0);

    // saturation: hold (0,0) for 300 cycles
    rst = 1'b0;
    set_xy(0, 0);
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (i == 254) check("sat_cnt_254", 32'(border_cnt), 32'd254);
      if (i == 255) check("sat_cnt_255", 32'(border_cnt), 32'd255);
      if (i == 256) check("sat_cnt_256", 32'(border_cnt), 32'd255);
    end
    check("sat_cnt_300", 32'(border_cnt), 32'd255);

    // reset mid-count at 100 with (0,0) applied
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 100; i++) tick();
    check("mid_cnt_100", 32'(border_cnt), 32'd100);
    rst = 1'b1;
    #1;
    check("mid_border_pre", 32'(isBorder), 32'd1);
    tick();
    check("mid_cnt_clr", 32'(border_cnt), 32'd0);
    check("mid_border_q_clr", 32'(border_q), 32'd0);
    check("mid_border_post", 32'(isBorder), 32'd1);
    rst = 1'b0;
    tick();
    check("mid_cnt_resume", 32'(border_cnt), 32'd1);
    check("mid_border_q_resume", 32'(border_q), 32'd1);

    clk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
